// File: rtl/bus_pkg.sv
// Shared bus-terminal definitions: default sizing, destination field, packet type.
package bus_pkg;

  localparam int unsigned PCKG_SZ   = 16;
  localparam int unsigned DEEP_FIFO = 8;
  localparam int unsigned DEST_MSB  = PCKG_SZ - 1;
  localparam int unsigned DEST_LSB  = PCKG_SZ - 8;
  localparam int unsigned DEST_W    = DEST_MSB - DEST_LSB + 1;

  typedef logic [PCKG_SZ-1:0] pkt_t;

  // Destination ID the arbiter routes on
  function automatic logic [DEST_W-1:0] dest_id(input pkt_t p);
    return p[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with saturating count and sticky overflow.
module sync_fifo_fwft #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [width-1:0]             din,
  input  logic                         rd,
  output logic [width-1:0]             dout,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         ovf
);

  localparam int unsigned CW = $clog2(depth + 1);
  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_rd_c;
  logic             do_wr_c;

  // Explicit wrap so non-power-of-two depths work
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign full    = (count == CW'(depth));
  assign dout    = valid ? mem[rd_ptr] : '0;
  assign do_rd_c = rd && valid;
  // A read frees the slot this same edge, so full+read+write is accepted
  assign do_wr_c = wr && (!full || do_rd_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr_c) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd_c) rd_ptr <= next_ptr(rd_ptr);
      if (do_wr_c && !do_rd_c)      count <= count + CW'(1);
      else if (do_rd_c && !do_wr_c) count <= count - CW'(1);
      if (wr && !do_wr_c) ovf <= 1'b1;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_terminal_fifo.sv
// Per-port terminal: TX FIFO toward the bus arbiter, RX FIFO toward the device.
module bus_terminal_fifo
  import bus_pkg::*;
#(
  parameter int unsigned pckg_sz   = PCKG_SZ,
  parameter int unsigned deep_fifo = DEEP_FIFO
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [pckg_sz-1:0]                 wr_data,
  output logic                               tx_full,
  output logic [$clog2(deep_fifo+1)-1:0]     tx_count,
  output logic                               tx_overflow,
  output logic                               pndng,
  output logic [pckg_sz-1:0]                 D_pop,
  input  logic                               pop,
  input  logic                               push,
  input  logic [pckg_sz-1:0]                 D_push,
  output logic                               rx_pndng,
  output logic [pckg_sz-1:0]                 rd_data,
  input  logic                               rd_en,
  output logic [$clog2(deep_fifo+1)-1:0]     rx_count,
  output logic                               rx_overflow
);

  sync_fifo_fwft #(.width(pckg_sz), .depth(deep_fifo)) u_tx (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_en),
    .din   (wr_data),
    .rd    (pop),
    .dout  (D_pop),
    .valid (pndng),
    .full  (tx_full),
    .count (tx_count),
    .ovf   (tx_overflow)
  );

  logic rx_full;

  sync_fifo_fwft #(.width(pckg_sz), .depth(deep_fifo)) u_rx (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .din   (D_push),
    .rd    (rd_en),
    .dout  (rd_data),
    .valid (rx_pndng),
    .full  (rx_full),
    .count (rx_count),
    .ovf   (rx_overflow)
  );

  // RX full is visible to the device only through rx_count
  logic unused_c;
  assign unused_c = rx_full;

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Self-checking bench for bus_terminal_fifo: vector table, directed corner cases, random vs queue model.
module tb_bus_terminal_fifo;
  import bus_pkg::*;

  localparam int unsigned D  = 8;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  pkt_t          wr_data = '0;
  logic          tx_full;
  logic [CW-1:0] tx_count;
  logic          tx_overflow;
  logic          pndng;
  pkt_t          D_pop;
  logic          pop = 1'b0;
  logic          push = 1'b0;
  pkt_t          D_push = '0;
  logic          rx_pndng;
  pkt_t          rd_data;
  logic          rd_en = 1'b0;
  logic [CW-1:0] rx_count;
  logic          rx_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_terminal_fifo #(.pckg_sz(16), .deep_fifo(D)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_count(tx_count),
    .tx_overflow(tx_overflow), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rx_pndng(rx_pndng), .rd_data(rd_data),
    .rd_en(rd_en), .rx_count(rx_count), .rx_overflow(rx_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later
  task automatic cyc(input logic w, input pkt_t wd, input logic p,
                     input logic ps, input pkt_t dp, input logic r);
    wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic wr; pkt_t wd; logic p; logic ps; pkt_t dp; logic r;
    logic e_pndng; pkt_t e_dpop; logic [CW-1:0] e_txc;
    logic e_rxp;   pkt_t e_rd;   logic [CW-1:0] e_rxc;
  } vec_t;

  vec_t vecs [13];

  // Behavioural model state for the random phase
  pkt_t tx_q[$];
  pkt_t rx_q[$];
  logic m_txo, m_rxo;

  initial begin
    // wr pop push D_push rd | pndng D_pop txc | rxp rd_data rxc
    vecs[0]  = '{1,16'h0102,0, 0,16'h0000,0, 1,16'h0102,1, 0,16'h0000,0};
    vecs[1]  = '{0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 0,16'h0000,0};
    vecs[2]  = '{0,16'h0000,0, 1,16'h0203,0, 0,16'h0000,0, 1,16'h0203,1};
    vecs[3]  = '{0,16'h0000,0, 1,16'h0204,0, 0,16'h0000,0, 1,16'h0203,2};
    vecs[4]  = '{0,16'h0000,0, 0,16'h0000,1, 0,16'h0000,0, 1,16'h0204,1};
    vecs[5]  = '{0,16'h0000,1, 0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0};
    vecs[6]  = '{0,16'h0000,1, 0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0};
    vecs[7]  = '{0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 0,16'h0000,0};
    vecs[8]  = '{0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 0,16'h0000,0};
    vecs[9]  = '{1,16'h0A0B,1, 0,16'h0000,0, 1,16'h0A0B,1, 0,16'h0000,0};
    vecs[10] = '{1,16'h0E0F,1, 1,16'h0C0D,0, 1,16'h0E0F,1, 1,16'h0C0D,1};
    vecs[11] = '{0,16'h0000,0, 1,16'h1111,1, 1,16'h0E0F,1, 1,16'h1111,1};
    vecs[12] = '{0,16'h0000,1, 0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0};

    // Reset state
    @(posedge clk); #1;
    chk("rst_pndng", 32'(pndng), 0);
    chk("rst_rx_pndng", 32'(rx_pndng), 0);
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_dpop", 32'(D_pop), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_full", 32'(tx_full), 0);
    chk("rst_ovf", 32'({tx_overflow, rx_overflow}), 0);
    reset = 1'b0;

    // Vector table: single-cycle behaviour incl. empty pop/rd and simultaneous ops
    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].wr, vecs[i].wd, vecs[i].p, vecs[i].ps, vecs[i].dp, vecs[i].r);
      chk($sformatf("v%0d_pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
      chk($sformatf("v%0d_dpop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
      chk($sformatf("v%0d_txc", i), 32'(tx_count), 32'(vecs[i].e_txc));
      chk($sformatf("v%0d_rxp", i), 32'(rx_pndng), 32'(vecs[i].e_rxp));
      chk($sformatf("v%0d_rd", i), 32'(rd_data), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_rxc", i), 32'(rx_count), 32'(vecs[i].e_rxc));
      chk($sformatf("v%0d_ovf", i), 32'({tx_overflow, rx_overflow}), 0);
    end

    // Fill TX, overflow, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 16'h0100 + 16'(i), 0, 0, 0, 0);
    chk("fill_full", 32'(tx_full), 1);
    chk("fill_count", 32'(tx_count), 8);
    chk("fill_ovf", 32'(tx_overflow), 0);
    cyc(1, 16'h01FF, 0, 0, 0, 0);
    chk("ovf_flag", 32'(tx_overflow), 1);
    chk("ovf_count", 32'(tx_count), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(D_pop), 32'(16'h0100 + 16'(i)));
      cyc(0, 0, 1, 0, 0, 0);
    end
    chk("drain_pndng", 32'(pndng), 0);
    chk("drain_dpop", 32'(D_pop), 0);
    chk("ovf_sticky", 32'(tx_overflow), 1);

    // Full + write + pop in the same cycle is legal
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 16'h0300 + 16'(i), 0, 0, 0, 0);
    cyc(1, 16'h03AA, 1, 0, 0, 0);
    chk("fwp_count", 32'(tx_count), 8);
    chk("fwp_ovf", 32'(tx_overflow), 0);
    chk("fwp_full", 32'(tx_full), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fwp_drain_%0d", i), 32'(D_pop),
          (i == 7) ? 32'h03AA : 32'(16'h0301 + 16'(i)));
      cyc(0, 0, 1, 0, 0, 0);
    end
    chk("fwp_empty", 32'(pndng), 0);

    // RX overflow, then leave 3 RX and 5 TX entries before a mid-cycle reset
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 16'h0400 + 16'(i), 0);
    chk("rx_ovf", 32'(rx_overflow), 1);
    chk("rx_full_count", 32'(rx_count), 8);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("rx_after_drain", 32'(rd_data), 32'h0405);
    for (int i = 0; i < 5; i++) cyc(1, 16'h0500 + 16'(i), 0, 0, 0, 0);
    cyc(1, 16'h05FF, 0, 0, 0, 0);
    cyc(1, 16'h05FE, 0, 0, 0, 0);
    cyc(1, 16'h05FD, 0, 0, 0, 0);
    cyc(1, 16'h05FC, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 16'h05FB, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("pre_rst_tx", 32'(tx_count), 5);
    chk("pre_rst_rx", 32'(rx_count), 3);
    for (int i = 0; i < 4; i++) cyc(1, 16'h0600, 0, 0, 0, 0);
    chk("pre_rst_txovf", 32'(tx_overflow), 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("pre_rst_tx5", 32'(tx_count), 5);
    #3 reset = 1'b1;
    #1;
    chk("async_pndng", 32'(pndng), 0);
    chk("async_rxp", 32'(rx_pndng), 0);
    chk("async_counts", 32'({tx_count, rx_count}), 0);
    chk("async_ovf", 32'({tx_overflow, rx_overflow}), 0);
    chk("async_dpop", 32'(D_pop), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1, 16'h0102, 0, 0, 0, 0);
    chk("post_rst_pndng", 32'(pndng), 1);
    chk("post_rst_dpop", 32'(D_pop), 32'h0102);
    chk("post_rst_cnt", 32'(tx_count), 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("post_rst_pop", 32'({pndng, D_pop}), 0);

    // Random traffic against a queue model, with fill/balanced/drain phases
    do_reset();
    tx_q.delete(); rx_q.delete(); m_txo = 0; m_rxo = 0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 150; c++) begin
        logic w, p, ps, r;
        pkt_t wd, dp;
        int unsigned wpct, rpct;
        bit tx_rd, rx_rd;
        wpct = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
        rpct = 100 - wpct;
        w  = ($urandom_range(0, 99) < wpct);
        p  = ($urandom_range(0, 99) < rpct);
        ps = ($urandom_range(0, 99) < wpct);
        r  = ($urandom_range(0, 99) < rpct);
        wd = 16'($urandom);
        dp = 16'($urandom);
        cyc(w, wd, p, ps, dp, r);
        tx_rd = p && (tx_q.size() != 0);
        if (tx_rd) void'(tx_q.pop_front());
        if (w) begin
          if (tx_q.size() < D) tx_q.push_back(wd);
          else m_txo = 1;
        end
        rx_rd = r && (rx_q.size() != 0);
        if (rx_rd) void'(rx_q.pop_front());
        if (ps) begin
          if (rx_q.size() < D) rx_q.push_back(dp);
          else m_rxo = 1;
        end
        chk("rnd_pndng", 32'(pndng), 32'(tx_q.size() != 0));
        chk("rnd_dpop", 32'(D_pop), (tx_q.size() != 0) ? 32'(tx_q[0]) : 0);
        chk("rnd_txc", 32'(tx_count), tx_q.size());
        chk("rnd_full", 32'(tx_full), 32'(tx_q.size() == D));
        chk("rnd_txo", 32'(tx_overflow), 32'(m_txo));
        chk("rnd_rxp", 32'(rx_pndng), 32'(rx_q.size() != 0));
        chk("rnd_rd", 32'(rd_data), (rx_q.size() != 0) ? 32'(rx_q[0]) : 0);
        chk("rnd_rxc", 32'(rx_count), rx_q.size());
        chk("rnd_rxo", 32'(rx_overflow), 32'(m_rxo));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
